stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Single-clock control and scheduling block for the stopwatch's shared minutes/seconds counter.
- Synchronizes and debounces the raw buttons and switches, and owns the pause and adjust mode state machine.
- Decides, on every cycle, which source may increment the counter: the 1 Hz run tick or the 2 Hz adjust tick.
- Replaces the derived-clock scheme with one-cycle enables on `clk`, and also drives the display blink enables.

Parameters:
- DB_CYCLES, 2000000: cycles an input must be stable before its debounced level changes (20 ms at 100 MHz).
- RUN_DIV, 100000000: clk cycles per run tick (1 Hz).
- ADJ_DIV, 50000000: clk cycles per adjust tick (2 Hz).
- BLINK_DIV, 25000000: clk cycles per blink phase toggle.

Ports:
- clk  in  1  master clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- rst_button  in  1  raw clear button, asynchronous to clk.
- pause_button  in  1  raw pause button, asynchronous.
- adj_switch  in  1  raw adjust switch, asynchronous.
- sel_switch  in  1  raw select switch, asynchronous; 0 = minutes, 1 = seconds.
- sec_inc  out  1  one-cycle pulse: increment seconds.
- min_inc  out  1  one-cycle pulse: increment minutes.
- carry_en  out  1  1 = counter carries seconds 59->0 into minutes; 0 = seconds wrap alone.
- cnt_clr  out  1  one-cycle pulse: clear minutes and seconds to 0.
- paused  out  1  pause flag.
- mode  out  2  state: 0 RUN, 1 PAUSED, 2 ADJ_MIN, 3 ADJ_SEC.
- blink_min  out  1  blank the minute digits while high.
- blink_sec  out  1  blank the second digits while high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0 and mode goes to RUN.
  - Debounced levels, the blink phase and all prescalers go to 0.
  - Synchronizer flops go to 0.
- Input conditioning:
  - Each raw input passes through a 2-flop synchronizer.
  - A per-input debounce counter runs while the synchronized value differs from the debounced level, and resets on any cycle where they are equal.
  - When the counter reaches DB_CYCLES, the debounced level takes the synchronized value.
  - Raw edge to debounced change takes DB_CYCLES+2 cycles.
  - Rising-edge pulses are derived from debounced rst_button and pause_button, registered, asserting 1 cycle after the debounced change.
- Clear:
  - A clear edge drives cnt_clr=1 for 1 cycle, sets paused to 0 and zeroes the run prescaler in the same cycle.
  - A tick coinciding with cnt_clr is suppressed; cnt_clr wins.
- Pause:
  - A pause edge toggles paused on the next edge, in any mode.
  - A pause edge coinciding with a clear edge leaves paused=0.
- State machine, evaluated every cycle:
  - adj_db=1 and sel_db=0 -> ADJ_MIN.
  - adj_db=1 and sel_db=1 -> ADJ_SEC.
  - adj_db=0 -> PAUSED if paused, else RUN.
  - Toggling pause while in ADJ_* changes only the flag; the flag takes effect on adjust exit.
- Run prescaler:
  - Counts 0..RUN_DIV-1 only in RUN and wraps at the top.
  - At terminal count, sec_inc=1 for that cycle.
  - Outside RUN it holds its value, so a pause/resume keeps the partial second.
- Adjust prescaler:
  - Counts 0..ADJ_DIV-1 only in ADJ_*.
  - Forced to 0 on the cycle mode changes into ADJ_MIN or ADJ_SEC, including ADJ_MIN<->ADJ_SEC.
  - The first adjust pulse occurs ADJ_DIV cycles after entry, then every ADJ_DIV cycles.
  - Terminal count drives min_inc in ADJ_MIN and sec_inc in ADJ_SEC.
- carry_en is 1 only in RUN.
- sec_inc and min_inc are never both high in the same cycle.
- No increment pulses occur in PAUSED.
- Blink:
  - A free-running counter toggles blink_phase every BLINK_DIV cycles.
  - blink_min = (mode==ADJ_MIN) & blink_phase.
  - blink_sec = (mode==ADJ_SEC) & blink_phase.
- All outputs are registered.
- rst mid-debounce or mid-prescale discards the partial count.

Test Plan:
Bench parameters: DB_CYCLES=4, RUN_DIV=10, ADJ_DIV=5, BLINK_DIV=3.
1. Reset, all inputs 0, run 100 cycles -> sec_inc pulses exactly 10 times, 10 cycles apart; min_inc=0; carry_en=1; mode=0.
2. pause_button high 3 cycles, then low -> no toggle, paused stays 0. Hold high 10 cycles -> paused=1 at DB_CYCLES+3 cycles after the raw edge, mode=1, no sec_inc. A second press resumes, with the first sec_inc arriving exactly the remaining partial-second count later.
3. adj_switch=1, sel_switch=0 -> mode=2 and carry_en=0; min_inc every 5 cycles, first one 5 cycles after mode change. Set sel_switch=1 -> mode=3; prescaler restarts; sec_inc 5 cycles later.
4. In mode 2, check blink_min toggles every 3 cycles and blink_sec=0; in RUN both are 0.
5. rst_button press while paused=1 -> one cnt_clr pulse, paused=0, mode=0. Force a run tick in the same cycle as cnt_clr -> no sec_inc that cycle.
6. Assert rst mid-prescale, in mode 3, with paused=1 -> the next cycle shows all outputs 0 and mode=0; the first sec_inc comes 10 cycles after rst deasserts.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: input conditioning, pause/adjust mode FSM and
// single-clock increment, clear and blink enables for the min:sec counter.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 2000000,
    parameter int RUN_DIV   = 100000000,
    parameter int ADJ_DIV   = 50000000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_button,
    input  logic       pause_button,
    input  logic       adj_switch,
    input  logic       sel_switch,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       carry_en,
    output logic       cnt_clr,
    output logic       paused,
    output logic [1:0] mode,
    output logic       blink_min,
    output logic       blink_sec
);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int RW  = $clog2(RUN_DIV + 1);
    localparam int AW  = $clog2(ADJ_DIV + 1);
    localparam int BW  = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSED  = 2'd1,
        ADJ_MIN = 2'd2,
        ADJ_SEC = 2'd3
    } mode_e;

    logic [3:0]     raw, s1_q, s2_q, db_q, db_d;
    logic [DBW-1:0] dbc_q [4];
    logic [DBW-1:0] dbc_d [4];
    logic [1:0]     prev_q;
    mode_e          state_q, state_d;
    logic           paused_q, paused_d;
    logic [RW-1:0]  run_q, run_d;
    logic [AW-1:0]  adj_q, adj_d;
    logic [BW-1:0]  blk_q, blk_d;
    logic           phase_q, phase_d;
    logic           sec_q, sec_d, min_q, min_d;
    logic           carry_q, carry_d, clr_q, clr_d;
    logic           bmin_q, bmin_d, bsec_q, bsec_d;
    logic           clr_edge, pause_edge, run_tick, adj_tick;

    // bit 0 clear, 1 pause, 2 adjust, 3 select
    assign raw = {sel_switch, adj_switch, pause_button, rst_button};

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            dbc_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (dbc_q[i] == DBW'(DB_CYCLES - 1))
                    db_d[i] = s2_q[i];
                else
                    dbc_d[i] = dbc_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        clr_edge   = db_q[0] & ~prev_q[0];
        pause_edge = db_q[1] & ~prev_q[1];

        paused_d = paused_q;
        if (clr_edge)
            paused_d = 1'b0;
        else if (pause_edge)
            paused_d = ~paused_q;

        state_d = RUN;
        if (db_q[2])
            state_d = db_q[3] ? ADJ_SEC : ADJ_MIN;
        else if (paused_d)
            state_d = PAUSED;

        // prescalers only advance while the mode is stable
        run_d    = run_q;
        run_tick = 1'b0;
        if (clr_edge) begin
            run_d = '0;
        end else if (state_q == RUN && state_d == RUN) begin
            if (run_q == RW'(RUN_DIV - 1)) begin
                run_d    = '0;
                run_tick = 1'b1;
            end else begin
                run_d = run_q + 1'b1;
            end
        end

        adj_d    = adj_q;
        adj_tick = 1'b0;
        if (state_d[1] && state_d != state_q) begin
            adj_d = '0;
        end else if (state_q[1] && state_d == state_q) begin
            if (adj_q == AW'(ADJ_DIV - 1)) begin
                adj_d    = '0;
                adj_tick = 1'b1;
            end else begin
                adj_d = adj_q + 1'b1;
            end
        end

        blk_d   = blk_q + 1'b1;
        phase_d = phase_q;
        if (blk_q == BW'(BLINK_DIV - 1)) begin
            blk_d   = '0;
            phase_d = ~phase_q;
        end

        sec_d   = ~clr_edge & (run_tick | (adj_tick & (state_q == ADJ_SEC)));
        min_d   = ~clr_edge & adj_tick & (state_q == ADJ_MIN);
        carry_d = (state_d == RUN);
        clr_d   = clr_edge;
        bmin_d  = (state_d == ADJ_MIN) & phase_d;
        bsec_d  = (state_d == ADJ_SEC) & phase_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            prev_q   <= '0;
            for (int i = 0; i < 4; i++)
                dbc_q[i] <= '0;
            state_q  <= RUN;
            paused_q <= 1'b0;
            run_q    <= '0;
            adj_q    <= '0;
            blk_q    <= '0;
            phase_q  <= 1'b0;
            sec_q    <= 1'b0;
            min_q    <= 1'b0;
            carry_q  <= 1'b0;
            clr_q    <= 1'b0;
            bmin_q   <= 1'b0;
            bsec_q   <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            db_q     <= db_d;
            prev_q   <= db_q[1:0];
            for (int i = 0; i < 4; i++)
                dbc_q[i] <= dbc_d[i];
            state_q  <= state_d;
            paused_q <= paused_d;
            run_q    <= run_d;
            adj_q    <= adj_d;
            blk_q    <= blk_d;
            phase_q  <= phase_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            carry_q  <= carry_d;
            clr_q    <= clr_d;
            bmin_q   <= bmin_d;
            bsec_q   <= bsec_d;
        end
    end

    assign sec_inc   = sec_q;
    assign min_inc   = min_q;
    assign carry_en  = carry_q;
    assign cnt_clr   = clr_q;
    assign paused    = paused_q;
    assign mode      = state_q;
    assign blink_min = bmin_q;
    assign blink_sec = bsec_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus random stimulus checked
// against a cycle-level behavioural model of the stopwatch controller.
module tb_stopwatch_ctrl;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int AD = 5;
    localparam int BD = 3;

    logic clk = 0;
    logic rst = 1;
    logic rb = 0, pb = 0, adj = 0, sel = 0;
    logic sec_inc, min_inc, carry_en, cnt_clr, paused;
    logic blink_min, blink_sec;
    logic [1:0] mode;
    logic [8:0] dut_v;
    logic [8:0] exp_v = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_p1[4], m_p2[4], m_db[4], m_cnt[4], m_prev[2];
    int m_paused = 0, m_mode = 0, m_run = 0, m_adj = 0;
    int m_blk = 0, m_phase = 0;

    stopwatch_ctrl #(
        .DB_CYCLES(DB), .RUN_DIV(RD), .ADJ_DIV(AD), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst(rst),
        .rst_button(rb), .pause_button(pb),
        .adj_switch(adj), .sel_switch(sel),
        .sec_inc(sec_inc), .min_inc(min_inc),
        .carry_en(carry_en), .cnt_clr(cnt_clr),
        .paused(paused), .mode(mode),
        .blink_min(blink_min), .blink_sec(blink_sec)
    );

    assign dut_v = {sec_inc, min_inc, carry_en, cnt_clr, paused,
                    mode, blink_min, blink_sec};

    always #5 clk = ~clk;

    // next registered outputs from the inputs sampled at the coming edge
    task automatic model_step();
        int r[4];
        int clr, pe, np, nm, trun, tadj, syn;
        r[0] = int'(rb); r[1] = int'(pb);
        r[2] = int'(adj); r[3] = int'(sel);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_p1[i] = 0; m_p2[i] = 0; m_db[i] = 0; m_cnt[i] = 0;
            end
            m_prev[0] = 0; m_prev[1] = 0;
            m_paused = 0; m_mode = 0; m_run = 0; m_adj = 0;
            m_blk = 0; m_phase = 0;
            exp_v = '0;
            return;
        end
        clr = (m_db[0] != 0 && m_prev[0] == 0) ? 1 : 0;
        pe  = (m_db[1] != 0 && m_prev[1] == 0) ? 1 : 0;
        np  = clr ? 0 : (pe ? 1 - m_paused : m_paused);
        nm  = m_db[2] ? (m_db[3] ? 3 : 2) : (np ? 1 : 0);
        trun = 0;
        if (clr) m_run = 0;
        else if (m_mode == 0 && nm == 0) begin
            m_run++;
            if (m_run == RD) begin m_run = 0; trun = 1; end
        end
        tadj = 0;
        if (nm >= 2 && nm != m_mode) m_adj = 0;
        else if (m_mode >= 2 && nm == m_mode) begin
            m_adj++;
            if (m_adj == AD) begin m_adj = 0; tadj = 1; end
        end
        m_blk++;
        if (m_blk == BD) begin m_blk = 0; m_phase = 1 - m_phase; end
        exp_v[8]   = (!clr && (trun != 0 || (tadj != 0 && m_mode == 3)));
        exp_v[7]   = (!clr && tadj != 0 && m_mode == 2);
        exp_v[6]   = (nm == 0);
        exp_v[5]   = (clr != 0);
        exp_v[4]   = (np != 0);
        exp_v[3:2] = 2'(nm);
        exp_v[1]   = (nm == 2 && m_phase != 0);
        exp_v[0]   = (nm == 3 && m_phase != 0);
        m_prev[0] = m_db[0];
        m_prev[1] = m_db[1];
        for (int i = 0; i < 4; i++) begin
            syn = m_p2[i];
            if (syn != m_db[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == DB) begin m_db[i] = syn; m_cnt[i] = 0; end
            end else begin
                m_cnt[i] = 0;
            end
            m_p2[i] = m_p1[i];
            m_p1[i] = r[i];
        end
        m_mode = nm;
        m_paused = np;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1; rb = 0; pb = 0; adj = 0; sel = 0;
        step();
        step();
        rst = 0;
        cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_v !== 9'd0) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", dut_v, 9'd0);
        end
    endtask

    task automatic test_run();
        int n = 0;
        logic e_s;
        do_reset();
        while (cyc < 100) begin
            step();
            e_s = (cyc % RD == 0);
            if (sec_inc === 1'b1) n++;
            checks++;
            if (sec_inc !== e_s || min_inc !== 1'b0 ||
                carry_en !== 1'b1 || mode !== 2'd0) begin
                errors++;
                $display("FAIL run cyc %0d got sec %b min %b carry %b mode %0d exp sec %b min 0 carry 1 mode 0",
                         cyc, sec_inc, min_inc, carry_en, mode, e_s);
            end
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL run_count got %0d exp 10", n);
        end
    endtask

    task automatic test_pause();
        logic e_p, e_s;
        do_reset();
        while (cyc < 52) begin
            if (cyc == 0)  pb = 1;
            if (cyc == 3)  pb = 0;
            if (cyc == 12) pb = 1;
            if (cyc == 22) pb = 0;
            if (cyc == 40) pb = 1;
            if (cyc == 50) pb = 0;
            step();
            e_p = (cyc >= 19 && cyc < 47);
            e_s = (cyc == 10 || cyc == 49);
            checks++;
            if (paused !== e_p || mode !== {1'b0, e_p} || sec_inc !== e_s) begin
                errors++;
                $display("FAIL pause cyc %0d got paused %b mode %0d sec %b exp %b %0d %b",
                         cyc, paused, mode, sec_inc, e_p, {1'b0, e_p}, e_s);
            end
        end
    endtask

    task automatic test_adjust();
        logic [1:0] e_m;
        logic e_min, e_sec, e_c;
        do_reset();
        while (cyc < 40) begin
            if (cyc == 0)  begin adj = 1; sel = 0; end
            if (cyc == 20) sel = 1;
            step();
            e_m   = (cyc >= 27) ? 2'd3 : (cyc >= 7) ? 2'd2 : 2'd0;
            e_min = (cyc == 12 || cyc == 17 || cyc == 22);
            e_sec = (cyc == 32 || cyc == 37);
            e_c   = (cyc < 7);
            checks++;
            if (mode !== e_m || min_inc !== e_min ||
                sec_inc !== e_sec || carry_en !== e_c) begin
                errors++;
                $display("FAIL adjust cyc %0d got mode %0d min %b sec %b carry %b exp %0d %b %b %b",
                         cyc, mode, min_inc, sec_inc, carry_en, e_m, e_min, e_sec, e_c);
            end
        end
    endtask

    task automatic test_blink();
        logic e_b;
        do_reset();
        while (cyc < 30) begin
            if (cyc == 0) adj = 1;
            step();
            e_b = (cyc >= 7) && ((cyc / BD) % 2 == 1);
            checks++;
            if (blink_min !== e_b || blink_sec !== 1'b0) begin
                errors++;
                $display("FAIL blink cyc %0d got bmin %b bsec %b exp %b 0",
                         cyc, blink_min, blink_sec, e_b);
            end
        end
    endtask

    task automatic test_clear();
        logic e_p, e_c, e_s;
        do_reset();
        while (cyc < 40) begin
            if (cyc == 0)  pb = 1;
            if (cyc == 10) pb = 0;
            if (cyc == 20) rb = 1;
            if (cyc == 30) rb = 0;
            step();
            e_p = (cyc >= 7 && cyc < 27);
            e_c = (cyc == 27);
            e_s = (cyc == 37);
            checks++;
            if (paused !== e_p || mode !== {1'b0, e_p} ||
                cnt_clr !== e_c || sec_inc !== e_s) begin
                errors++;
                $display("FAIL clear cyc %0d got paused %b mode %0d clr %b sec %b exp %b %0d %b %b",
                         cyc, paused, mode, cnt_clr, sec_inc, e_p, {1'b0, e_p}, e_c, e_s);
            end
        end
        do_reset();
        while (cyc < 22) begin
            if (cyc == 3)  rb = 1;
            if (cyc == 12) rb = 0;
            step();
            e_c = (cyc == 10);
            e_s = (cyc == 20);
            checks++;
            if (cnt_clr !== e_c || sec_inc !== e_s) begin
                errors++;
                $display("FAIL clear_vs_tick cyc %0d got clr %b sec %b exp %b %b",
                         cyc, cnt_clr, sec_inc, e_c, e_s);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic e_s;
        do_reset();
        while (cyc < 20) begin
            if (cyc == 0)  pb = 1;
            if (cyc == 10) begin pb = 0; adj = 1; sel = 1; end
            step();
        end
        checks++;
        if (mode !== 2'd3 || paused !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup got mode %0d paused %b exp 3 1", mode, paused);
        end
        rst = 1; adj = 0; sel = 0;
        step();
        rst = 0;
        cyc = 0;
        checks++;
        if (dut_v !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b exp %b", dut_v, 9'd0);
        end
        while (cyc < 12) begin
            step();
            e_s = (cyc == 10);
            checks++;
            if (sec_inc !== e_s || mode !== 2'd0) begin
                errors++;
                $display("FAIL rst_mid_run cyc %0d got sec %b mode %0d exp %b 0",
                         cyc, sec_inc, mode, e_s);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 11) == 0) rb  = ~rb;
            if ($urandom_range(0, 7)  == 0) pb  = ~pb;
            if ($urandom_range(0, 15) == 0) adj = ~adj;
            if ($urandom_range(0, 9)  == 0) sel = ~sel;
            rst = ($urandom_range(0, 299) == 0);
            step();
            checks++;
            if (dut_v !== exp_v) begin
                errors++;
                $display("FAIL random n %0d got %b exp %b (sec min carry clr paused mode bmin bsec)",
                         n, dut_v, exp_v);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_adjust();
        test_blink();
        test_clear();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
